// File: rtl/lc3_pkg.sv
// Shared LC-3 types and constants used across the datapath stages.
package lc3_pkg;

    typedef logic [15:0] word_t;

    localparam word_t LC3_RESET_PC = 16'h3000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_t;

endpackage

// File: rtl/lc3_pc_reg.sv
// LC-3 program counter: reset > redirect > increment > hold.
module lc3_pc_reg
    import lc3_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter logic [15:0] RESET_PC = LC3_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC[ADDR_W-1:0];
        else if (load)
            pc <= target;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch: one outstanding read, IR held until accepted.
module lc3_fetch_unit
    import lc3_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 16,
    parameter logic [15:0] RESET_PC = LC3_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_accept,
    output logic [ADDR_W-1:0] pc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target
);

    fetch_state_t state;
    logic         capture;

    // A redirect in the capture cycle drops the word and skips the increment
    assign capture  = (state == FETCH) && mem_ready && !pc_load;
    assign mem_req  = (state == FETCH) && !rst;
    assign mem_addr = pc;

    lc3_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst    (rst),
        .load   (pc_load),
        .target (pc_target),
        .inc    (capture),
        .pc     (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else if (pc_load) begin
            state    <= FETCH;
            ir_valid <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir       <= mem_rdata;
                        ir_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (ir_accept) begin
                        ir_valid <= 1'b0;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed checks for the LC-3 fetch stage.
module tb_lc3_fetch_unit;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_accept;
    logic [15:0] pc;
    logic        pc_load;
    logic [15:0] pc_target;

    int tests_run;
    int tests_failed;

    lc3_fetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_accept (ir_accept),
        .pc        (pc),
        .pc_load   (pc_load),
        .pc_target (pc_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        mem_rdata = 16'h0000;
        mem_ready = 1'b0;
        ir_accept = 1'b0;
        pc_load   = 1'b0;
        pc_target = 16'h0000;
        step();
        step();
        chk("rst_req", {15'd0, mem_req}, 16'd0);
        chk("rst_pc", pc, 16'h3000);
        chk("rst_valid", {15'd0, ir_valid}, 16'd0);
        chk("rst_ir", ir, 16'h0000);

        // 1: immediate ready
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'h1261;
        #1;
        chk("t1_req", {15'd0, mem_req}, 16'd1);
        chk("t1_addr", mem_addr, 16'h3000);
        step();
        chk("t1_ir", ir, 16'h1261);
        chk("t1_valid", {15'd0, ir_valid}, 16'd1);
        chk("t1_pc", pc, 16'h3001);
        chk("t1_hold_req", {15'd0, mem_req}, 16'd0);

        // 2: ready delayed 3 cycles
        rst       = 1'b1;
        mem_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", {15'd0, mem_req}, 16'd1);
            chk("t2_addr", mem_addr, 16'h3000);
            step();
        end
        chk("t2_novalid", {15'd0, ir_valid}, 16'd0);
        mem_ready = 1'b1;
        mem_rdata = 16'h5020;
        step();
        chk("t2_ir", ir, 16'h5020);
        chk("t2_pc", pc, 16'h3001);

        // 3: consumer stalls 5 cycles while memory keeps offering data
        mem_rdata = 16'hABCD;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_ir", ir, 16'h5020);
            chk("t3_pc", pc, 16'h3001);
            chk("t3_valid", {15'd0, ir_valid}, 16'd1);
            chk("t3_req", {15'd0, mem_req}, 16'd0);
        end
        mem_ready = 1'b0;
        ir_accept = 1'b1;
        step();
        chk("t3_acc_valid", {15'd0, ir_valid}, 16'd0);
        chk("t3_acc_req", {15'd0, mem_req}, 16'd1);
        chk("t3_acc_addr", mem_addr, 16'h3001);
        step();
        chk("t3_idle_acc_valid", {15'd0, ir_valid}, 16'd0);
        chk("t3_idle_acc_addr", mem_addr, 16'h3001);
        ir_accept = 1'b0;

        // 4: redirect in the capture cycle
        mem_ready = 1'b1;
        mem_rdata = 16'h1111;
        pc_load   = 1'b1;
        pc_target = 16'h0400;
        step();
        pc_load = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("t4_valid", {15'd0, ir_valid}, 16'd0);
        chk("t4_pc", pc, 16'h0400);
        chk("t4_addr", mem_addr, 16'h0400);
        chk("t4_req", {15'd0, mem_req}, 16'd1);
        chk("t4_ir_kept", ir, 16'h5020);

        // 4b: redirect together with accept in HOLD
        mem_ready = 1'b1;
        mem_rdata = 16'h2222;
        step();
        chk("t4b_ir", ir, 16'h2222);
        chk("t4b_pc", pc, 16'h0401);
        mem_ready = 1'b0;
        ir_accept = 1'b1;
        pc_load   = 1'b1;
        pc_target = 16'h0800;
        step();
        ir_accept = 1'b0;
        pc_load   = 1'b0;
        #1;
        chk("t4b_valid", {15'd0, ir_valid}, 16'd0);
        chk("t4b_pc2", pc, 16'h0800);
        chk("t4b_ir_kept", ir, 16'h2222);
        chk("t4b_req", {15'd0, mem_req}, 16'd1);

        // 5: pc wrap
        pc_load   = 1'b1;
        pc_target = 16'hFFFF;
        step();
        pc_load = 1'b0;
        #1;
        chk("t5_addr", mem_addr, 16'hFFFF);
        mem_ready = 1'b1;
        mem_rdata = 16'h3333;
        step();
        mem_ready = 1'b0;
        chk("t5_pc", pc, 16'h0000);
        chk("t5_ir", ir, 16'h3333);
        chk("t5_valid", {15'd0, ir_valid}, 16'd1);

        // 6: reset mid-fetch, then reset with redirect
        ir_accept = 1'b1;
        step();
        ir_accept = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_req_in_rst", {15'd0, mem_req}, 16'd0);
        step();
        chk("t6_pc", pc, 16'h3000);
        chk("t6_valid", {15'd0, ir_valid}, 16'd0);
        chk("t6_ir", ir, 16'h0000);
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'h4444;
        step();
        mem_ready = 1'b0;
        chk("t6_cap_pc", pc, 16'h3001);
        rst       = 1'b1;
        pc_load   = 1'b1;
        pc_target = 16'h0123;
        #1;
        chk("t6_rl_req", {15'd0, mem_req}, 16'd0);
        step();
        chk("t6_rl_pc", pc, 16'h3000);
        chk("t6_rl_valid", {15'd0, ir_valid}, 16'd0);
        chk("t6_rl_ir", ir, 16'h0000);
        rst     = 1'b0;
        pc_load = 1'b0;
        #1;
        chk("t6_post_req", {15'd0, mem_req}, 16'd1);
        chk("t6_post_addr", mem_addr, 16'h3000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
